// File: rtl/cpu_defs.sv
// Shared CPU definitions: branch funct3 encodings, datapath width, PC increment and
// compare-mode codes.
package cpu_defs;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic [1:0] {
    SIGNED   = 2'b00,
    UNSIGNED = 2'b01
  } cmp_op_e;

  // funct3[1] separates the unsigned (BLTU/BGEU) from the signed less-than branches
  function automatic cmp_op_e cmp_op_of(input logic [2:0] funct3);
    return funct3[1] ? UNSIGNED : SIGNED;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Branch request/result bundle between issue, the resolve unit and the fetch/PC side.
interface branch_resolve_unit_if #(
  parameter int unsigned XLEN = cpu_defs::XLEN
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] op_a_i;
  logic [XLEN-1:0] op_b_i;
  logic [XLEN-1:0] pc_i;
  logic [XLEN-1:0] imm_i;
  logic            pred_taken_i;
  logic            valid_o;
  logic            ready_i;
  logic            taken_o;
  logic [XLEN-1:0] target_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            illegal_o;
  logic            misalign_o;

  modport master (
    output valid_i, funct3_i, op_a_i, op_b_i, pc_i, imm_i, pred_taken_i, ready_i,
    input  ready_o, valid_o, taken_o, target_o, redirect_o, redirect_pc_o, illegal_o,
           misalign_o
  );

  modport slave (
    input  valid_i, funct3_i, op_a_i, op_b_i, pc_i, imm_i, pred_taken_i, ready_i,
    output ready_o, valid_o, taken_o, target_o, redirect_o, redirect_pc_o, illegal_o,
           misalign_o
  );
endinterface

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational branch comparator: equality, signed and unsigned less-than, using the
// same sign-bit / difference scheme as the ALU.
module branch_cmp #(
  parameter int unsigned XLEN = cpu_defs::XLEN
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            eq,
  output logic            lt_s,
  output logic            lt_u
);
  logic [XLEN-1:0] diff;

  always_comb begin
    diff = op_a - op_b;
    eq   = (diff == '0);
    // Differing signs decide directly; otherwise the difference cannot overflow
    lt_s = (op_a[XLEN-1] ^ op_b[XLEN-1]) ? op_a[XLEN-1] : diff[XLEN-1];
    lt_u = (op_a < op_b);
  end
endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: compares operands, computes target/next PC and mispredict redirect
// behind a one-entry valid/ready output register. BRANCH_STATS_EN adds branch counters.
module branch_resolve_unit
  import cpu_defs::*;
#(
  parameter int unsigned     XLEN    = cpu_defs::XLEN,
  parameter logic [XLEN-1:0] PC_STEP = cpu_defs::PC_STEP
`ifdef BRANCH_STATS_EN
  ,
  parameter int unsigned     CNT_W   = 32
`endif
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  branch_resolve_unit_if.slave   br
`ifdef BRANCH_STATS_EN
  ,
  output logic [CNT_W-1:0]       br_count_o,
  output logic [CNT_W-1:0]       mispredict_count_o
`endif
);

  logic            eq, lt_s, lt_u, lt;
  logic            accept;
  logic            taken_d, illegal_d, misalign_d, redirect_d;
  logic [XLEN-1:0] target_d, fallthrough, redirect_pc_d;

  logic            valid_q, taken_q, illegal_q, misalign_q, redirect_q;
  logic [XLEN-1:0] target_q, redirect_pc_q;

  branch_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .op_a (br.op_a_i),
    .op_b (br.op_b_i),
    .eq   (eq),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  assign br.ready_o = !valid_q || br.ready_i;
  assign accept     = br.valid_i && br.ready_o && !flush_i;

  always_comb begin
    lt        = (cmp_op_of(br.funct3_i) == UNSIGNED) ? lt_u : lt_s;
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    unique case (br.funct3_i)
      BR_BEQ:  taken_d = eq;
      BR_BNE:  taken_d = !eq;
      BR_BLT,
      BR_BLTU: taken_d = lt;
      BR_BGE,
      BR_BGEU: taken_d = !lt;
      default: illegal_d = 1'b1;
    endcase
    target_d      = br.pc_i + br.imm_i;
    fallthrough   = br.pc_i + PC_STEP;
    misalign_d    = taken_d && (target_d[1:0] != 2'b00);
    // A misaligned target raises an exception instead of redirecting fetch
    redirect_d    = (taken_d != br.pred_taken_i) && !illegal_d && !misalign_d;
    redirect_pc_d = taken_d ? target_d : fallthrough;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= 1'b0;
      taken_q       <= 1'b0;
      illegal_q     <= 1'b0;
      misalign_q    <= 1'b0;
      redirect_q    <= 1'b0;
      target_q      <= '0;
      redirect_pc_q <= '0;
    end else if (accept) begin
      valid_q       <= 1'b1;
      taken_q       <= taken_d;
      illegal_q     <= illegal_d;
      misalign_q    <= misalign_d;
      redirect_q    <= redirect_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
    end else if (flush_i || br.ready_i) begin
      valid_q       <= 1'b0;
    end
  end

  assign br.valid_o       = valid_q;
  assign br.taken_o       = taken_q;
  assign br.illegal_o     = illegal_q;
  assign br.misalign_o    = misalign_q;
  assign br.redirect_o    = redirect_q;
  assign br.target_o      = target_q;
  assign br.redirect_pc_o = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic             consume;
  logic [CNT_W-1:0] br_cnt_q, mis_cnt_q;

  // A flushed result is discarded, not consumed
  assign consume = valid_q && br.ready_i && !flush_i && !illegal_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else if (consume) begin
      if (br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
      if (redirect_q && (mis_cnt_q != '1)) mis_cnt_q <= mis_cnt_q + 1'b1;
    end
  end

  assign br_count_o         = br_cnt_q;
  assign mispredict_count_o = mis_cnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed scoreboard bench for branch_resolve_unit; counter checks under BRANCH_STATS_EN.
module tb_branch_resolve_unit;
  import cpu_defs::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  branch_resolve_unit_if br_if ();

`ifdef BRANCH_STATS_EN
  logic [31:0] br_count, mis_count;
`endif

  branch_resolve_unit dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .flush_i            (flush),
    .br                 (br_if)
`ifdef BRANCH_STATS_EN
    ,
    .br_count_o         (br_count),
    .mispredict_count_o (mis_count)
`endif
  );

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic        redirect;
    logic [31:0] rpc;
    logic        illegal;
    logic        misalign;
  } exp_t;

  exp_t        q[$];
  bit          m_valid;
  int unsigned m_br, m_mis;
  int unsigned compared, mismatched;

  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] pc, input logic [31:0] imm, input logic pred);
    exp_t e;
    logic ls, lu;
    ls = $signed(a) < $signed(b);
    lu = a < b;
    e = '0;
    case (f3)
      3'b000:  e.taken = (a == b);
      3'b001:  e.taken = (a != b);
      3'b100:  e.taken = ls;
      3'b101:  e.taken = !ls;
      3'b110:  e.taken = lu;
      3'b111:  e.taken = !lu;
      default: e.illegal = 1'b1;
    endcase
    e.target   = pc + imm;
    e.misalign = e.taken && (e.target[1:0] != 2'b00);
    e.redirect = (e.taken != pred) && !e.illegal && !e.misalign;
    e.rpc      = e.taken ? e.target : pc + 32'd4;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                       input logic pred, input logic rdy, input logic fl);
    br_if.valid_i      = v;
    br_if.funct3_i     = f3;
    br_if.op_a_i       = a;
    br_if.op_b_i       = b;
    br_if.pc_i         = pc;
    br_if.imm_i        = imm;
    br_if.pred_taken_i = pred;
    br_if.ready_i      = rdy;
    flush              = fl;
  endtask

  task automatic idle(input logic rdy);
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, rdy, 1'b0);
  endtask

  // Advance one clock: predict from the driven inputs, then compare after the edge
  task automatic step(input string tag);
    bit   m_ready;
    exp_t e;
    #1;
    m_ready = !m_valid || br_if.ready_i;
    if (rst) begin
      q.delete();
      m_valid = 1'b0;
      m_br    = 0;
      m_mis   = 0;
    end else begin
      check({tag, "_ready"}, {31'b0, br_if.ready_o}, {31'b0, m_ready});
      if (m_valid && br_if.ready_i && !flush && !q[0].illegal) begin
        m_br++;
        if (q[0].redirect) m_mis++;
      end
      if (m_valid && (br_if.ready_i || flush)) begin
        void'(q.pop_front());
        m_valid = 1'b0;
      end
      if (br_if.valid_i && m_ready && !flush) begin
        q.push_back(model(br_if.funct3_i, br_if.op_a_i, br_if.op_b_i, br_if.pc_i,
                          br_if.imm_i, br_if.pred_taken_i));
        m_valid = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, {31'b0, br_if.valid_o}, {31'b0, m_valid});
    if (m_valid) begin
      e = q[0];
      check({tag, "_taken"}, {31'b0, br_if.taken_o}, {31'b0, e.taken});
      check({tag, "_target"}, br_if.target_o, e.target);
      check({tag, "_redirect"}, {31'b0, br_if.redirect_o}, {31'b0, e.redirect});
      check({tag, "_rpc"}, br_if.redirect_pc_o, e.rpc);
      check({tag, "_illegal"}, {31'b0, br_if.illegal_o}, {31'b0, e.illegal});
      check({tag, "_misalign"}, {31'b0, br_if.misalign_o}, {31'b0, e.misalign});
    end
`ifdef BRANCH_STATS_EN
    check({tag, "_brcnt"}, br_count, m_br);
    check({tag, "_miscnt"}, mis_count, m_mis);
`endif
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_valid    = 1'b0;
    rst        = 1'b1;
    idle(1'b1);
    @(posedge clk);
    #1;
    step("rst");
    check("rst_taken", {31'b0, br_if.taken_o}, 32'h0);
    check("rst_target", br_if.target_o, 32'h0);
    check("rst_rpc", br_if.redirect_pc_o, 32'h0);
    check("rst_flags", {28'b0, br_if.redirect_o, br_if.illegal_o, br_if.misalign_o,
                        br_if.valid_o}, 32'h0);
    rst = 1'b0;

    // Signed compare across sign boundary, then unsigned on the same operands
    drive(1'b1, BR_BLT, 32'hFFFF_FFFF, 32'h1, 32'h100, 32'h20, 1'b0, 1'b1, 1'b0);
    step("blt");
    check("blt_target_const", br_if.target_o, 32'h120);
    drive(1'b1, BR_BGEU, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40, 1'b1, 1'b1, 1'b0);
    step("bgeu");
    drive(1'b1, BR_BLTU, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40, 1'b1, 1'b1, 1'b0);
    step("bltu");
    check("bltu_rpc_const", br_if.redirect_pc_o, 32'h304);

    // Stall: capture, hold three cycles with a pending request, then release
    drive(1'b1, BR_BEQ, 32'h5, 32'h5, 32'h400, 32'h10, 1'b1, 1'b1, 1'b0);
    step("cap");
    drive(1'b1, BR_BNE, 32'h7, 32'h9, 32'h500, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b0);
    step("stall0");
    step("stall1");
    step("stall2");
    br_if.ready_i = 1'b1;
    step("release");

    // Flush with an incoming branch while a result is held
    drive(1'b1, BR_BLT, 32'h1, 32'h2, 32'h600, 32'h8, 1'b0, 1'b0, 1'b0);
    step("hold");
    drive(1'b1, BR_BGE, 32'h3, 32'h2, 32'h700, 32'h8, 1'b0, 1'b0, 1'b1);
    step("flush");
    idle(1'b1);
    step("idle0");

    drive(1'b1, 3'b010, 32'h1, 32'h1, 32'h800, 32'h8, 1'b1, 1'b1, 1'b0);
    step("illegal");
    drive(1'b1, BR_BEQ, 32'hA, 32'hA, 32'hFFFF_FFF0, 32'h12, 1'b0, 1'b1, 1'b0);
    step("misalign");
    check("misalign_target_const", br_if.target_o, 32'h2);
    idle(1'b1);
    step("idle1");

    // Flush discards a held result even when downstream is ready
    drive(1'b1, BR_BGE, 32'h8000_0000, 32'h1, 32'h900, 32'h4, 1'b1, 1'b0, 1'b0);
    step("hold2");
    drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
    step("flush_rdy");

    // Reset mid-handshake
    drive(1'b1, BR_BNE, 32'h1, 32'h2, 32'hA00, 32'h10, 1'b0, 1'b0, 1'b0);
    step("hold3");
    rst = 1'b1;
    step("rst_mid");
    rst = 1'b0;
    idle(1'b1);
    step("idle2");

    // Five consumed branches, two mispredicted
    drive(1'b1, BR_BEQ, 32'h1, 32'h1, 32'h1000, 32'h8, 1'b1, 1'b1, 1'b0);
    step("s0");
    drive(1'b1, BR_BNE, 32'h1, 32'h1, 32'h1010, 32'h8, 1'b0, 1'b1, 1'b0);
    step("s1");
    drive(1'b1, BR_BLT, 32'h1, 32'h2, 32'h1020, 32'h8, 1'b0, 1'b1, 1'b0);
    step("s2");
    drive(1'b1, BR_BGEU, 32'h1, 32'h2, 32'h1030, 32'h8, 1'b1, 1'b1, 1'b0);
    step("s3");
    drive(1'b1, BR_BLTU, 32'h3, 32'h2, 32'h1040, 32'h8, 1'b0, 1'b1, 1'b0);
    step("s4");
    idle(1'b1);
    step("s_end");
`ifdef BRANCH_STATS_EN
    check("stats_br5", br_count, 32'd5);
    check("stats_mis2", mis_count, 32'd2);
    rst = 1'b1;
    step("stats_rst");
    rst = 1'b0;
    check("stats_rst_br", br_count, 32'd0);
    check("stats_rst_mis", mis_count, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule
